nukv_fifo_pkt: RTL and testbench

- Single-clock, parametrised, first-word-fall-through (FWFT) AXI-stream FIFO built on inferred block RAM. It is the successor to the macro-based nukv FIFO.
- Adds the following over the macro-based FIFO: any data width, any depth, exact occupancy reporting, a parametrised almost-full margin and an optional packet (store-and-forward) mode that uses tlast.
- Used between nukv pipeline stages that need elastic buffering or must receive only whole packets.

---
 rtl/nukv_fifo_pkt.sv | 129 ++++++++++++
 tb/tb_nukv_fifo_pkt.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nukv_fifo_pkt.sv
// Single-clock FWFT stream FIFO on inferred block RAM. An optional packet mode only presents whole packets.
// Latency: a word written into an empty FIFO is valid two cycles later, then one word per cycle.
// Backpressure: tready drops when count reaches DEPTH. The output holds its word until m_axis_tready.
module nukv_fifo_pkt #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDR_BITS    = 9,
    parameter int AFULL_MARGIN = 7,
    parameter int PKT_MODE     = 0,
    parameter int INIT_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 s_axis_talmostfull,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [ADDR_BITS:0]   count,
    output logic [ADDR_BITS:0]   pkt_count,
    output logic                 err_oversize
);
    localparam int W = DATA_SIZE + 1;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT  = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] AFULL_THR = FULL_CNT - (ADDR_BITS+1)'(AFULL_MARGIN);

    logic [W-1:0]         mem [DEPTH];
    logic [ADDR_BITS:0]   wr_ptr, rd_ptr;
    logic [W-1:0]         rd_q;
    logic                 rd_vld;
    logic [W-1:0]         out_q;
    logic                 out_vld;
    logic [3:0]           init_cnt;
    logic                 init_done;
    logic                 cut_thru;
    logic                 wr_fire, rd_fire, wr_last, rd_last;
    logic                 ram_nonempty, out_take, s1_move, ram_rd, ovf_trig;
    logic [ADDR_BITS:0]   count_nxt, pkt_nxt;

    // Handshake, prefetch pipeline control and next-state counters
    always_comb begin
        init_done     = (init_cnt == 4'(INIT_CYCLES));
        s_axis_tready = ~rst & init_done & (count < FULL_CNT);
        m_axis_tvalid = (PKT_MODE != 0) ? (out_vld & ((pkt_count != '0) | cut_thru)) : out_vld;
        wr_fire       = s_axis_tvalid & s_axis_tready;
        rd_fire       = m_axis_tvalid & m_axis_tready;
        wr_last       = wr_fire & s_axis_tlast;
        rd_last       = rd_fire & out_q[DATA_SIZE];
        ram_nonempty  = (wr_ptr != rd_ptr);
        // The output register can take a word when empty or being consumed this cycle
        out_take      = ~out_vld | rd_fire;
        s1_move       = rd_vld & out_take;
        ram_rd        = ram_nonempty & (~rd_vld | s1_move);
        // A packet that fills the whole FIFO without a tlast can never complete, so it is released cut-through
        ovf_trig      = (PKT_MODE != 0) && (count == FULL_CNT) && (pkt_count == '0);
        count_nxt     = count;
        if (wr_fire && !rd_fire)
            count_nxt = count + 1'b1;
        else if (!wr_fire && rd_fire)
            count_nxt = count - 1'b1;
        pkt_nxt = pkt_count;
        if (wr_last && !rd_last)
            pkt_nxt = pkt_count + 1'b1;
        else if (!wr_last && rd_last)
            pkt_nxt = pkt_count - 1'b1;
    end

    assign m_axis_tdata = out_q[DATA_SIZE-1:0];
    assign m_axis_tlast = out_q[DATA_SIZE];

    // Storage write; the contents need no reset because the pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr[ADDR_BITS-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // Registered RAM read into the first pipeline stage
    always_ff @(posedge clk) begin
        if (ram_rd)
            rd_q <= mem[rd_ptr[ADDR_BITS-1:0]];
    end

    // Pointers, pipeline valids, output register, counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            rd_vld             <= 1'b0;
            out_vld            <= 1'b0;
            out_q              <= '0;
            count              <= '0;
            pkt_count          <= '0;
            s_axis_talmostfull <= 1'b0;
            err_oversize       <= 1'b0;
            cut_thru           <= 1'b0;
            init_cnt           <= '0;
        end else begin
            if (!init_done)
                init_cnt <= init_cnt + 1'b1;
            if (wr_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (ram_rd)
                rd_vld <= 1'b1;
            else if (s1_move)
                rd_vld <= 1'b0;
            if (s1_move) begin
                out_q   <= rd_q;
                out_vld <= 1'b1;
            end else if (rd_fire) begin
                out_vld <= 1'b0;
            end
            count              <= count_nxt;
            pkt_count          <= pkt_nxt;
            s_axis_talmostfull <= (count_nxt >= AFULL_THR);
            if (ovf_trig)
                err_oversize <= 1'b1;
            if (rd_last)
                cut_thru <= 1'b0;
            else if (ovf_trig)
                cut_thru <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nukv_fifo_pkt.sv
// Bench for nukv_fifo_pkt: three instances (plain depth 16, plain depth 8, packet mode depth 16).
// Inputs are driven on the falling edge. Each falling edge checks outputs against a scoreboard and counter model.
// Expected words are queued when a write is accepted and compared when a read is taken.
module tb_nukv_fifo_pkt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] sd [3];
    logic [15:0] md [3];
    logic [2:0]  sl, sv, mr, sr, saf, ml, mv, eo;
    logic [4:0]  cnt0, cnt2, pc0, pc2;
    logic [3:0]  cnt1, pc1;

    nukv_fifo_pkt #(.DATA_SIZE(16), .ADDR_BITS(4), .AFULL_MARGIN(7), .PKT_MODE(0), .INIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .s_axis_tdata(sd[0]), .s_axis_tlast(sl[0]), .s_axis_tvalid(sv[0]),
        .s_axis_tready(sr[0]), .s_axis_talmostfull(saf[0]), .m_axis_tdata(md[0]), .m_axis_tlast(ml[0]),
        .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]), .count(cnt0), .pkt_count(pc0), .err_oversize(eo[0]));
    nukv_fifo_pkt #(.DATA_SIZE(16), .ADDR_BITS(3), .AFULL_MARGIN(7), .PKT_MODE(0), .INIT_CYCLES(2)) u1 (
        .clk(clk), .rst(rst), .s_axis_tdata(sd[1]), .s_axis_tlast(sl[1]), .s_axis_tvalid(sv[1]),
        .s_axis_tready(sr[1]), .s_axis_talmostfull(saf[1]), .m_axis_tdata(md[1]), .m_axis_tlast(ml[1]),
        .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]), .count(cnt1), .pkt_count(pc1), .err_oversize(eo[1]));
    nukv_fifo_pkt #(.DATA_SIZE(16), .ADDR_BITS(4), .AFULL_MARGIN(7), .PKT_MODE(1), .INIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .s_axis_tdata(sd[2]), .s_axis_tlast(sl[2]), .s_axis_tvalid(sv[2]),
        .s_axis_tready(sr[2]), .s_axis_talmostfull(saf[2]), .m_axis_tdata(md[2]), .m_axis_tlast(ml[2]),
        .m_axis_tvalid(mv[2]), .m_axis_tready(mr[2]), .count(cnt2), .pkt_count(pc2), .err_oversize(eo[2]));

    localparam int DEP [3] = '{16, 8, 16};
    localparam int THR [3] = '{9, 1, 9};

    int checks = 0;
    int failures = 0;
    int mcnt [3];
    int mpkt [3];
    int npop [3];
    int rel_cnt = 0;
    logic        prev_hold [3];
    logic [16:0] prev_word [3];
    logic [16:0] q0[$], q1[$], q2[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    function automatic int get_cnt(input int i);
        return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
    endfunction
    function automatic int get_pc(input int i);
        return (i == 0) ? int'(pc0) : (i == 1) ? int'(pc1) : int'(pc2);
    endfunction
    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    endfunction
    task automatic qpush(input int i, input logic [16:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask
    task automatic qpop(input int i, output logic [16:0] v);
        case (i)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask
    task automatic qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Check one instance for the cycle whose inputs were just driven, then update the model.
    task automatic obs(input int i);
        logic [16:0] w, exp_w;
        logic rd, wr;
        if (rst) begin
            qclear(i);
            mcnt[i] = 0;
            mpkt[i] = 0;
            prev_hold[i] = 1'b0;
            return;
        end
        chk($sformatf("count%0d", i), get_cnt(i), mcnt[i]);
        chk($sformatf("pkt_count%0d", i), get_pc(i), mpkt[i]);
        chk($sformatf("tready%0d", i), sr[i], (rel_cnt >= 2) && (mcnt[i] < DEP[i]));
        chk($sformatf("afull%0d", i), saf[i], mcnt[i] >= THR[i]);
        if (i != 2) chk($sformatf("err_plain%0d", i), eo[i], 0);
        w = {ml[i], md[i]};
        if (prev_hold[i]) begin
            chk($sformatf("hold_vld%0d", i), mv[i], 1);
            chk($sformatf("hold_dat%0d", i), w, prev_word[i]);
        end
        if (mv[i]) chk($sformatf("vld_has_data%0d", i), qsize(i) > 0, 1);
        rd = mv[i] & mr[i];
        wr = sv[i] & sr[i];
        if (rd) begin
            npop[i]++;
            mcnt[i]--;
            if (qsize(i) > 0) begin
                qpop(i, exp_w);
                chk($sformatf("rd_word%0d", i), w, exp_w);
                if (exp_w[16]) mpkt[i]--;
            end else if (ml[i]) begin
                mpkt[i]--;
            end
        end
        if (wr) begin
            qpush(i, {sl[i], sd[i]});
            mcnt[i]++;
            if (sl[i]) mpkt[i]++;
        end
        prev_hold[i] = mv[i] & ~mr[i];
        prev_word[i] = w;
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) obs(i);
        if (rst) rel_cnt = 0;
        else rel_cnt++;
        @(negedge clk);
    endtask

    initial begin
        int idx, first_af, nw, maxc, base, vcount, full_cyc, err_cyc, cyc;
        logic f, done;
        rst = 1'b1;
        sv = '0; sl = '0; mr = '0;
        for (int i = 0; i < 3; i++) begin
            sd[i] = '0; npop[i] = 0; mcnt[i] = 0; mpkt[i] = 0; prev_hold[i] = 1'b0; prev_word[i] = '0;
        end
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state and init hold, then first-word latency
        chk("rst_count", cnt0, 0);
        chk("rst_vld", mv, 3'b000);
        chk("rst_pkt", pc2, 0);
        chk("rst_afull", saf, 3'b000);
        chk("rst_err", eo, 3'b000);
        chk("rst_tdata", {ml[0], md[0]}, 0);
        sv[0] = 1'b1; sd[0] = 16'h00A5; sl[0] = 1'b0;
        chk("init_hold_c1", sr, 3'b000);
        tick();
        chk("init_hold_c2", sr, 3'b000);
        tick();
        chk("init_done", sr[0], 1);
        tick();                       // write accepted at this edge (k)
        sv[0] = 1'b0;
        chk("lat_k1_vld", mv[0], 0);
        tick();
        chk("lat_k2m_vld", mv[0], 0);
        tick();
        chk("lat_k2_vld", mv[0], 1);
        chk("lat_k2_dat", md[0], 16'h00A5);
        chk("lat_k2_cnt", cnt0, 1);
        mr[0] = 1'b1;
        tick();
        mr[0] = 1'b0;
        tick();

        // Fill depth 16 with the consumer stalled, then drain in order
        idx = 0; first_af = -1; base = npop[0];
        for (int t = 0; t < 60 && idx < 16; t++) begin
            sv[0] = 1'b1; sd[0] = 16'(idx);
            if (saf[0] && first_af < 0) first_af = int'(cnt0);
            f = sv[0] & sr[0];
            tick();
            if (f) idx++;
        end
        if (saf[0] && first_af < 0) first_af = int'(cnt0);
        chk("fill_done", idx, 16);
        chk("afull_at", first_af, 9);
        tick();
        chk("full_cnt", cnt0, 16);
        chk("full_tready", sr[0], 0);
        sv[0] = 1'b0;
        mr[0] = 1'b1;
        for (int t = 0; t < 60 && q0.size() > 0; t++) tick();
        chk("drain_cnt", npop[0] - base, 16);
        mr[0] = 1'b0;
        tick();

        // Random valid/ready on depth 8 with many pointer wraps
        nw = 0; maxc = 0; base = npop[1];
        for (int t = 0; t < 60000 && (nw < 10000 || q1.size() > 0); t++) begin
            sv[1] = (nw < 10000) && ($urandom_range(1, 0) == 1);
            sd[1] = 16'($urandom);
            sl[1] = ($urandom_range(3, 0) == 0);
            mr[1] = ($urandom_range(1, 0) == 1);
            if (int'(cnt1) > maxc) maxc = int'(cnt1);
            f = sv[1] & sr[1];
            tick();
            if (f) nw++;
        end
        sv[1] = 1'b0; mr[1] = 1'b0; sl[1] = 1'b0;
        chk("rand_written", nw, 10000);
        chk("rand_read", npop[1] - base, 10000);
        chk("rand_max_le8", maxc <= 8, 1);
        tick();

        // Packet mode: a slowly written 5-word packet is held until its tlast arrives
        mr[2] = 1'b1; base = npop[2];
        for (int w = 0; w < 5; w++) begin
            sv[2] = 1'b1; sd[2] = 16'h0100 + 16'(w); sl[2] = (w == 4);
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                f = sv[2] & sr[2];
                tick();
                done = f;
            end
            chk("pkt_wr_accept", done, 1);
            sv[2] = 1'b0; sl[2] = 1'b0;
            if (w < 4) begin
                for (int t = 0; t < 3; t++) begin
                    chk("pkt_gate", mv[2], 0);
                    tick();
                end
            end
        end
        tick();
        tick();
        chk("pkt_vld_k2", mv[2], 1);
        chk("pkt_count_1", pc2, 1);
        for (int t = 0; t < 12; t++) tick();
        chk("pkt_count_0", pc2, 0);
        chk("pkt_words", npop[2] - base, 5);

        // Packet mode: a 20-word packet overflows depth 16 and is released cut-through
        mr[2] = 1'b0; idx = 0; base = npop[2]; full_cyc = -1; err_cyc = -1; cyc = 0;
        for (int t = 0; t < 300 && (idx < 20 || q2.size() > 0); t++) begin
            sv[2] = (idx < 20); sd[2] = 16'h0200 + 16'(idx); sl[2] = (idx == 19);
            if (cnt2 == 5'd16 && full_cyc < 0) full_cyc = cyc;
            if (eo[2] && err_cyc < 0) begin
                err_cyc = cyc;
                mr[2] = 1'b1;
            end
            f = sv[2] & sr[2];
            tick();
            cyc++;
            if (f) idx++;
        end
        sv[2] = 1'b0; sl[2] = 1'b0;
        chk("ovf_reached_full", full_cyc >= 0, 1);
        chk("ovf_err_seen", err_cyc >= 0, 1);
        chk("ovf_err_latency", (err_cyc - full_cyc) <= 2 && err_cyc >= full_cyc, 1);
        chk("ovf_words", npop[2] - base, 20);
        for (int t = 0; t < 5; t++) tick();
        chk("ovf_err_sticky", eo[2], 1);
        chk("ovf_pkt_0", pc2, 0);

        // Reset with words stored and the consumer mid-read
        mr[0] = 1'b0;
        for (int w = 0; w < 7; w++) begin
            sv[0] = 1'b1; sd[0] = 16'h0300 + 16'(w);
            tick();
        end
        sv[0] = 1'b0;
        tick();
        tick();
        mr[0] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", cnt0, 0);
        chk("mid_rst_vld", mv, 3'b000);
        chk("mid_rst_pkt", pc0, 0);
        chk("mid_rst_err", eo[2], 0);
        vcount = 0;
        for (int t = 0; t < 20; t++) begin
            if (mv[0]) vcount++;
            tick();
        end
        chk("no_stale", vcount, 0);
        mr[0] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
